// File: rtl/axi_pkg.sv
// Shared AXI4 constants and types for the CPU-side master bridge.
package axi_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_e;

    // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY are successes.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_master_bridge_if.sv
// AXI4 master-port signal bundle (AR/R/AW/W/B channels).
interface axi_master_bridge_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [3:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/axi_master_bridge.sv
// CPU/cache request port to AXI4 master: single-beat writes, INCR read bursts,
// one outstanding transaction with a fixed ID.
module axi_master_bridge
    import axi_pkg::*;
#(
    parameter logic [3:0]  MASTER_ID = 4'd0,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [3:0]          req_len,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_last,
    output logic                rsp_err,

    axi_master_bridge_if.master axi
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [3:0]            len_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [3:0]            beat_cnt;
    logic                  beat_ovf_q;
    logic                  aw_done_q;
    logic                  w_done_q;

    logic ar_valid, r_ready, aw_valid, w_valid, b_ready;
    logic req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic beat_err;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_we ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (axi.ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (axi.RVALID && axi.RLAST) state_d = IDLE;
            end
            WR_REQ: begin
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if ((aw_done_q || axi.AWREADY) && (w_done_q || axi.WREADY))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (axi.BVALID) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_hs = req_valid && req_ready;
    assign ar_hs  = ar_valid && axi.ARREADY;
    assign r_hs   = r_ready  && axi.RVALID;
    assign aw_hs  = aw_valid && axi.AWREADY;
    assign w_hs   = w_valid  && axi.WREADY;
    assign b_hs   = b_ready  && axi.BVALID;

    // Extra beats past len are flagged even without RLAST; beat_ovf_q covers
    // the case where the saturated counter can no longer exceed len.
    assign beat_err = resp_is_err(axi.RRESP)
                    || (axi.RID != MASTER_ID)
                    || (axi.RLAST && (beat_cnt != len_q))
                    || (beat_cnt > len_q)
                    || beat_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            beat_cnt   <= '0;
            beat_ovf_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;

            if (req_hs) begin
                addr_q    <= req_addr;
                len_q     <= req_len;
                wdata_q   <= req_wdata;
                wstrb_q   <= req_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            if (ar_hs) begin
                beat_cnt   <= '0;
                beat_ovf_q <= 1'b0;
            end

            if (r_hs) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= axi.RDATA;
                rsp_last  <= axi.RLAST;
                rsp_err   <= beat_err;
                if (beat_cnt != 4'hF) beat_cnt <= beat_cnt + 4'd1;
                else if (!axi.RLAST)  beat_ovf_q <= 1'b1;
            end

            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;

            if (b_hs) begin
                rsp_valid <= 1'b1;
                rsp_last  <= 1'b1;
                rsp_err   <= resp_is_err(axi.BRESP) || (axi.BID != MASTER_ID);
            end
        end
    end

    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = SIZE_4B;
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARVALID = ar_valid;
    assign axi.RREADY  = r_ready;

    assign axi.AWID    = MASTER_ID;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = SIZE_4B;
    assign axi.AWBURST = BURST_INCR;
    assign axi.AWVALID = aw_valid;

    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WLAST   = 1'b1;
    assign axi.WVALID  = w_valid;

    assign axi.BREADY  = b_ready;

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: the bench plays the AXI slave and
// scoreboards every response pulse against expectations queued at the handshake.
module tb_axi_master_bridge;

    localparam logic [3:0] MID = 4'h5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_len, req_wstrb;
    logic        rsp_valid, rsp_last, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    axi_master_bridge_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) axi ();

    axi_master_bridge #(.MASTER_ID(MID), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .axi       (axi.master)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        last;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_rsp = 0;
    int n_aw  = 0;
    int n_w   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: count handshakes at the edge, then sample #1 after it.
    task automatic tick();
        rsp_t e;
        if (axi.AWVALID === 1'b1 && axi.AWREADY) n_aw++;
        if (axi.WVALID === 1'b1 && axi.WREADY)   n_w++;
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                chk("rsp_last",  {63'd0, rsp_last},  {63'd0, e.last});
                chk("rsp_err",   {63'd0, rsp_err},   {63'd0, e.err});
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] len,
                         input logic [31:0] wd, input logic [3:0] ws);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wd;
        req_wstrb = ws;
        tick();
        req_valid = 1'b0;
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len, input int waits);
        chk("arvalid",  {63'd0, axi.ARVALID}, 64'd1);
        chk("araddr",   {32'd0, axi.ARADDR},  {32'd0, addr});
        chk("arlen",    {60'd0, axi.ARLEN},   {60'd0, len});
        chk("arsize",   {61'd0, axi.ARSIZE},  64'd2);
        chk("arburst",  {62'd0, axi.ARBURST}, 64'd1);
        chk("arid",     {60'd0, axi.ARID},    {60'd0, MID});
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("ar_hold_valid", {63'd0, axi.ARVALID}, 64'd1);
            chk("ar_hold_addr",  {32'd0, axi.ARADDR},  {32'd0, addr});
            chk("ar_hold_len",   {60'd0, axi.ARLEN},   {60'd0, len});
        end
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        chk("arvalid_drop", {63'd0, axi.ARVALID}, 64'd0);
        chk("rready",       {63'd0, axi.RREADY},  64'd1);
    endtask

    task automatic r_beat(input logic [31:0] data, input logic [1:0] resp, input logic last,
                          input logic [3:0] id, input int gap, input logic exp_err);
        for (int i = 0; i < gap; i++) tick();
        axi.RVALID = 1'b1;
        axi.RDATA  = data;
        axi.RRESP  = resp;
        axi.RLAST  = last;
        axi.RID    = id;
        chk("rready_beat", {63'd0, axi.RREADY}, 64'd1);
        exp_q.push_back('{rdata: data, last: last, err: exp_err});
        tick();
        axi.RVALID = 1'b0;
        axi.RLAST  = 1'b0;
        axi.RID    = MID;
    endtask

    task automatic txn_end(input string tag);
        chk({tag, "_sb_empty"}, exp_q.size(), 64'd0);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                             input logic w_first, input logic [1:0] bresp, input logic exp_err);
        int aw0, w0;
        issue(1'b1, addr, 4'd0, wd, ws);
        aw0 = n_aw;
        w0  = n_w;
        chk("awvalid", {63'd0, axi.AWVALID}, 64'd1);
        chk("wvalid",  {63'd0, axi.WVALID},  64'd1);
        chk("awaddr",  {32'd0, axi.AWADDR},  {32'd0, addr});
        chk("awlen",   {60'd0, axi.AWLEN},   64'd0);
        chk("awsize",  {61'd0, axi.AWSIZE},  64'd2);
        chk("awburst", {62'd0, axi.AWBURST}, 64'd1);
        chk("awid",    {60'd0, axi.AWID},    {60'd0, MID});
        chk("wdata",   {32'd0, axi.WDATA},   {32'd0, wd});
        chk("wstrb",   {60'd0, axi.WSTRB},   {60'd0, ws});
        chk("wlast",   {63'd0, axi.WLAST},   64'd1);
        if (w_first) begin
            axi.WREADY = 1'b1;
            tick();
            axi.WREADY = 1'b0;
            chk("wvalid_drop",  {63'd0, axi.WVALID},  64'd0);
            chk("awvalid_hold", {63'd0, axi.AWVALID}, 64'd1);
            axi.AWREADY = 1'b1;
            tick();
            axi.AWREADY = 1'b0;
        end else begin
            axi.AWREADY = 1'b1;
            axi.WREADY  = 1'b1;
            tick();
            axi.AWREADY = 1'b0;
            axi.WREADY  = 1'b0;
        end
        chk("awvalid_done", {63'd0, axi.AWVALID}, 64'd0);
        chk("wvalid_done",  {63'd0, axi.WVALID},  64'd0);
        chk("bready",       {63'd0, axi.BREADY},  64'd1);
        for (int i = 0; i < 3; i++) tick();
        axi.BVALID = 1'b1;
        axi.BRESP  = bresp;
        axi.BID    = MID;
        exp_q.push_back('{rdata: 32'd0, last: 1'b1, err: exp_err});
        tick();
        axi.BVALID = 1'b0;
        chk("aw_hs_once", n_aw - aw0, 64'd1);
        chk("w_hs_once",  n_w - w0,   64'd1);
        txn_end("wr");
    endtask

    initial begin
        int n0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        axi.ARREADY = 1'b0;
        axi.RID     = MID;
        axi.RDATA   = '0;
        axi.RRESP   = '0;
        axi.RLAST   = 1'b0;
        axi.RVALID  = 1'b0;
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BID     = MID;
        axi.BRESP   = '0;
        axi.BVALID  = 1'b0;

        #1;
        chk("rst_arvalid",   {63'd0, axi.ARVALID}, 64'd0);
        chk("rst_rready",    {63'd0, axi.RREADY},  64'd0);
        chk("rst_awvalid",   {63'd0, axi.AWVALID}, 64'd0);
        chk("rst_wvalid",    {63'd0, axi.WVALID},  64'd0);
        chk("rst_bready",    {63'd0, axi.BREADY},  64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid},   64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata},   64'd0);
        chk("rst_araddr",    {32'd0, axi.ARADDR},  64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single read, zero-wait
        issue(1'b0, 32'h0000_1000, 4'd0, '0, '0);
        ar_phase(32'h0000_1000, 4'd0, 0);
        r_beat(32'hDEAD_BEEF, 2'b00, 1'b1, MID, 0, 1'b0);
        txn_end("rd1");

        // burst of 4 with AR wait states and R gaps
        issue(1'b0, 32'h0000_2000, 4'd3, '0, '0);
        ar_phase(32'h0000_2000, 4'd3, 2);
        n0 = n_rsp;
        r_beat(32'h10, 2'b00, 1'b0, MID, 0, 1'b0);
        r_beat(32'h20, 2'b00, 1'b0, MID, 1, 1'b0);
        r_beat(32'h30, 2'b00, 1'b0, MID, 2, 1'b0);
        r_beat(32'h40, 2'b00, 1'b1, MID, 0, 1'b0);
        chk("burst_pulses", n_rsp - n0, 64'd4);
        txn_end("burst");

        // default slave DECERR
        issue(1'b0, 32'hF000_0000, 4'd0, '0, '0);
        ar_phase(32'hF000_0000, 4'd0, 0);
        r_beat(32'h0, 2'b11, 1'b1, MID, 0, 1'b1);
        txn_end("decerr");

        // EXOKAY is not an error; wrong RID is
        issue(1'b0, 32'h0000_2400, 4'd1, '0, '0);
        ar_phase(32'h0000_2400, 4'd1, 1);
        r_beat(32'h5555_AAAA, 2'b01, 1'b0, MID, 0, 1'b0);
        r_beat(32'hAAAA_5555, 2'b00, 1'b1, 4'h2, 0, 1'b1);
        txn_end("rid");

        // writes: W before AW, then simultaneous with SLVERR
        write_txn(32'h0000_3000, 32'h1234_5678, 4'b0011, 1'b1, 2'b00, 1'b0);
        write_txn(32'h0000_3004, 32'hA5A5_0F0F, 4'b1111, 1'b0, 2'b10, 1'b1);

        // early RLAST on beat 2 of 4
        issue(1'b0, 32'h0000_6000, 4'd3, '0, '0);
        ar_phase(32'h0000_6000, 4'd3, 0);
        r_beat(32'hA1, 2'b00, 1'b0, MID, 0, 1'b0);
        r_beat(32'hA2, 2'b00, 1'b1, MID, 0, 1'b1);
        txn_end("early_last");

        // extra beat past len without RLAST, then RLAST
        issue(1'b0, 32'h0000_6100, 4'd0, '0, '0);
        ar_phase(32'h0000_6100, 4'd0, 0);
        r_beat(32'hB0, 2'b00, 1'b0, MID, 0, 1'b0);
        r_beat(32'hB1, 2'b00, 1'b1, MID, 0, 1'b1);
        txn_end("extra_beat");

        // reset in the middle of a read burst
        issue(1'b0, 32'h0000_4000, 4'd1, '0, '0);
        ar_phase(32'h0000_4000, 4'd1, 0);
        r_beat(32'hC1, 2'b00, 1'b0, MID, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_arvalid",   {63'd0, axi.ARVALID}, 64'd0);
        chk("midrst_rready",    {63'd0, axi.RREADY},  64'd0);
        chk("midrst_rsp_valid", {63'd0, rsp_valid},   64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        issue(1'b0, 32'h0000_5000, 4'd0, '0, '0);
        ar_phase(32'h0000_5000, 4'd0, 0);
        r_beat(32'hCAFE_F00D, 2'b00, 1'b1, MID, 0, 1'b0);
        txn_end("post_rst");

        tick();
        tick();
        chk("final_sb_empty", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
